// File: rtl/ram_ctrl_pkg.sv
// Shared RAM command encoding and arbiter FSM states.
// A RAM command word is {op[1:0], payload[7:0]}, one per cycle on the command strobe.
package ram_ctrl_pkg;

   localparam int NUM_REQ   = 2;
   localparam int OP_W      = 2;
   localparam int PAYLOAD_W = 8;
   localparam int CMD_W     = OP_W + PAYLOAD_W;
   localparam int WDATA_W   = 8;

   localparam logic [OP_W-1:0] OP_WADDR = 2'b00;
   localparam logic [OP_W-1:0] OP_WDATA = 2'b01;
   localparam logic [OP_W-1:0] OP_RADDR = 2'b10;
   localparam logic [OP_W-1:0] OP_RDATA = 2'b11;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      W_ADDR = 3'd1,
      W_DATA = 3'd2,
      R_ADDR = 3'd3,
      R_CMD  = 3'd4,
      R_WAIT = 3'd5,
      RESP   = 3'd6
   } state_t;

   typedef struct packed {
      logic [OP_W-1:0]      op;
      logic [PAYLOAD_W-1:0] payload;
   } ram_cmd_t;

   function automatic ram_cmd_t mk_cmd(input logic [OP_W-1:0] op,
                                       input logic [PAYLOAD_W-1:0] payload);
      ram_cmd_t c;
      c.op      = op;
      c.payload = payload;
      return c;
   endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: one-hot grant, combinational from req; no backpressure.
// The pointer moves only on advance, so a grant offered outside IDLE is never consumed.
module rr_arbiter_2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   // Index of the requester granted most recently; reset value makes requester 0 win first.
   logic last_q;
   logic last_d;

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (advance && (grant != 2'b00)) begin
         last_d = grant[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Arbitrates two requesters onto a serial RAM command port; write 2-3 cycles, read >= 4 cycles.
// Requesters hold their request until req_ready; RAM read latency is bounded by TIMEOUT cycles.
module ram_cmd_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_SIZE = 8,
   parameter int TIMEOUT   = 15
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0]             req_we,
   input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
   input  logic [NUM_REQ*WDATA_W-1:0]     req_wdata,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             rsp_valid,
   output logic [PAYLOAD_W-1:0]           rsp_rdata,
   output logic                           rsp_err,
   output logic [CMD_W-1:0]               ram_din,
   output logic                           ram_rx_valid,
   input  logic [PAYLOAD_W-1:0]           ram_dout,
   input  logic                           ram_tx_valid
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t                 state_q, state_d;
   logic                   gnt_q, gnt_d;
   logic [ADDR_SIZE-1:0]   addr_q, addr_d;
   logic [WDATA_W-1:0]     wdata_q, wdata_d;
   logic [ADDR_SIZE-1:0]   wc_addr_q, wc_addr_d;
   logic                   wc_vld_q, wc_vld_d;
   logic [ADDR_SIZE-1:0]   rc_addr_q, rc_addr_d;
   logic                   rc_vld_q, rc_vld_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [PAYLOAD_W-1:0]   rdata_q, rdata_d;
   logic                   err_q, err_d;

   logic                   in_idle;
   logic [NUM_REQ-1:0]     arb_grant;
   logic                   sel;
   logic                   sel_we;
   logic [ADDR_SIZE-1:0]   sel_addr;
   logic [WDATA_W-1:0]     sel_wdata;
   ram_cmd_t               cmd;

   assign in_idle = (state_q == IDLE);

   rr_arbiter_2 u_rr (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req_valid),
      .advance (in_idle),
      .grant   (arb_grant)
   );

   // The only req_valid -> req_ready path is the IDLE grant.
   assign req_ready = (in_idle && rst_n) ? arb_grant : '0;

   assign sel       = arb_grant[1];
   assign sel_we    = sel ? req_we[1] : req_we[0];
   assign sel_addr  = sel ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0];
   assign sel_wdata = sel ? req_wdata[2*WDATA_W-1:WDATA_W]    : req_wdata[WDATA_W-1:0];

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wc_addr_d = wc_addr_q;
      wc_vld_d  = wc_vld_q;
      rc_addr_d = rc_addr_q;
      rc_vld_d  = rc_vld_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_d     = err_q;

      unique case (state_q)
         IDLE: begin
            if (arb_grant != '0) begin
               gnt_d   = sel;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               // The RAM keeps its last write/read address, so a repeat address skips re-sending it.
               if (sel_we) begin
                  state_d = (wc_vld_q && (wc_addr_q == sel_addr)) ? W_DATA : W_ADDR;
               end else begin
                  state_d = (rc_vld_q && (rc_addr_q == sel_addr)) ? R_CMD : R_ADDR;
               end
            end
         end
         W_ADDR: begin
            wc_addr_d = addr_q;
            wc_vld_d  = 1'b1;
            state_d   = W_DATA;
         end
         W_DATA: begin
            state_d = IDLE;
         end
         R_ADDR: begin
            rc_addr_d = addr_q;
            rc_vld_d  = 1'b1;
            state_d   = R_CMD;
         end
         R_CMD: begin
            cnt_d   = '0;
            state_d = R_WAIT;
         end
         R_WAIT: begin
            if (ram_tx_valid) begin
               rdata_d = ram_dout;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               // After a timeout the RAM's address registers are suspect; force both to be re-sent.
               rdata_d  = '0;
               err_d    = 1'b1;
               wc_vld_d = 1'b0;
               rc_vld_d = 1'b0;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      cmd          = mk_cmd(OP_WADDR, '0);
      ram_rx_valid = 1'b0;
      rsp_valid    = '0;
      rsp_rdata    = '0;
      rsp_err      = 1'b0;

      unique case (state_q)
         W_ADDR: begin
            cmd          = mk_cmd(OP_WADDR, PAYLOAD_W'(addr_q));
            ram_rx_valid = 1'b1;
         end
         W_DATA: begin
            cmd          = mk_cmd(OP_WDATA, wdata_q);
            ram_rx_valid = 1'b1;
         end
         R_ADDR: begin
            cmd          = mk_cmd(OP_RADDR, PAYLOAD_W'(addr_q));
            ram_rx_valid = 1'b1;
         end
         R_CMD: begin
            cmd          = mk_cmd(OP_RDATA, '0);
            ram_rx_valid = 1'b1;
         end
         RESP: begin
            rsp_valid = gnt_q ? 2'b10 : 2'b01;
            rsp_rdata = rdata_q;
            rsp_err   = err_q;
         end
         default: begin
            cmd = mk_cmd(OP_WADDR, '0);
         end
      endcase
   end

   assign ram_din = cmd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         gnt_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wc_addr_q <= '0;
         wc_vld_q  <= 1'b0;
         rc_addr_q <= '0;
         rc_vld_q  <= 1'b0;
         cnt_q     <= '0;
         rdata_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wc_addr_q <= wc_addr_d;
         wc_vld_q  <= wc_vld_d;
         rc_addr_q <= rc_addr_d;
         rc_vld_q  <= rc_vld_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
      end
   end

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   a_rsp_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(rsp_valid));
   a_no_cmd_resp:  assert property (@(posedge clk) disable iff (!rst_n) !(ram_rx_valid && (rsp_valid != '0)));

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Directed bench for ram_cmd_arbiter: vector table of single transactions against a small RAM model,
// plus hand sequences for reset in R_WAIT and round-robin with both requesters busy.
module tb_ram_cmd_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_ready;
   logic [1:0]  rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic [9:0]  ram_din;
   logic        ram_rx_valid;
   logic [7:0]  ram_dout;
   logic        ram_tx_valid;

   int errors = 0;
   int checks = 0;
   int ram_dly = -1;

   ram_cmd_arbiter #(.ADDR_SIZE(8), .TIMEOUT(15)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_ready    (req_ready),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .ram_din      (ram_din),
      .ram_rx_valid (ram_rx_valid),
      .ram_dout     (ram_dout),
      .ram_tx_valid (ram_tx_valid)
   );

   always #5 clk = ~clk;

   // RAM model: latches addresses, stores write data, answers a read-data command after ram_dly cycles.
   logic [7:0] mem [256];
   logic [7:0] m_waddr = 8'h00;
   logic [7:0] m_raddr = 8'h00;
   int         pend = 0;

   initial begin
      ram_tx_valid = 1'b0;
      ram_dout     = 8'h00;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   end

   always @(negedge clk) begin
      ram_tx_valid = 1'b0;
      if (pend > 0) begin
         pend = pend - 1;
         if (pend == 0) begin
            ram_tx_valid = 1'b1;
            ram_dout     = mem[m_raddr];
         end
      end
      if (ram_rx_valid === 1'b1) begin
         case (ram_din[9:8])
            2'b00: m_waddr = ram_din[7:0];
            2'b01: mem[m_waddr] = ram_din[7:0];
            2'b10: m_raddr = ram_din[7:0];
            default: if (ram_dly > 0) pend = ram_dly;
         endcase
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      int         who;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      int         dly;
      int         ncmd;
      logic [9:0] c0;
      logic [9:0] c1;
      logic [1:0] rv;
      logic [7:0] rd;
      logic       re;
      int         wt;
   } vec_t;

   vec_t vecs [9];

   task automatic run_vec(input vec_t v, input int idx);
      logic [9:0] cmds [$];
      int         n;
      int         waitc;
      bit         done;
      bit         got_rsp;
      logic [1:0] rv;
      logic [7:0] rd;
      logic       re;
      ram_dly = v.dly;
      @(negedge clk);
      req_valid = 2'b00;
      req_valid[v.who] = 1'b1;
      req_we[v.who] = v.we;
      req_addr[v.who*8 +: 8] = v.addr;
      req_wdata[v.who*8 +: 8] = v.wdata;
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 10) begin
         @(negedge clk); #1; n++;
      end
      chk($sformatf("v%0d_grant", idx), 32'(req_ready), 32'(2'b01 << v.who));
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      done = 0; got_rsp = 0; waitc = 0; rv = '0; rd = '0; re = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         if (ram_rx_valid) begin
            cmds.push_back(ram_din);
         end else if (rsp_valid != 2'b00) begin
            got_rsp = 1; rv = rsp_valid; rd = rsp_rdata; re = rsp_err; done = 1;
         end else if (cmds.size() > 0) begin
            waitc++;
         end
         if (v.we && cmds.size() == v.ncmd) done = 1;
         if (!done) begin
            @(negedge clk); #1;
         end
      end
      chk($sformatf("v%0d_ncmd", idx), 32'(cmds.size()), 32'(v.ncmd));
      if (cmds.size() > 0) chk($sformatf("v%0d_cmd0", idx), 32'(cmds[0]), 32'(v.c0));
      if (v.ncmd == 2 && cmds.size() > 1) chk($sformatf("v%0d_cmd1", idx), 32'(cmds[1]), 32'(v.c1));
      chk($sformatf("v%0d_has_rsp", idx), 32'(got_rsp), 32'(!v.we));
      if (!v.we) begin
         chk($sformatf("v%0d_rsp_valid", idx), 32'(rv), 32'(v.rv));
         chk($sformatf("v%0d_rdata", idx), 32'(rd), 32'(v.rd));
         chk($sformatf("v%0d_err", idx), 32'(re), 32'(v.re));
         chk($sformatf("v%0d_wait_cycles", idx), 32'(waitc), 32'(v.wt));
      end
      @(negedge clk); #1;
      chk($sformatf("v%0d_quiet_after", idx), {29'd0, rsp_valid, ram_rx_valid}, 32'd0);
   endtask

   initial begin
      int         n;
      bit         seen;
      int         gcnt;
      int         gcyc [4];
      logic [1:0] gvec [4];
      logic [9:0] first_cmd;
      bit         have_cmd;

      vecs[0] = '{who:0, we:1, addr:8'h12, wdata:8'hA5, dly:-1, ncmd:2, c0:10'h012, c1:10'h1A5, rv:2'b00, rd:8'h00, re:1'b0, wt:0};
      vecs[1] = '{who:1, we:0, addr:8'h12, wdata:8'h00, dly:1,  ncmd:2, c0:10'h212, c1:10'h300, rv:2'b10, rd:8'hA5, re:1'b0, wt:1};
      vecs[2] = '{who:0, we:1, addr:8'h12, wdata:8'h3C, dly:-1, ncmd:1, c0:10'h13C, c1:10'h000, rv:2'b00, rd:8'h00, re:1'b0, wt:0};
      vecs[3] = '{who:0, we:1, addr:8'h13, wdata:8'h3C, dly:-1, ncmd:2, c0:10'h013, c1:10'h13C, rv:2'b00, rd:8'h00, re:1'b0, wt:0};
      vecs[4] = '{who:1, we:0, addr:8'h12, wdata:8'h00, dly:2,  ncmd:1, c0:10'h300, c1:10'h000, rv:2'b10, rd:8'h3C, re:1'b0, wt:2};
      vecs[5] = '{who:0, we:0, addr:8'h12, wdata:8'h00, dly:-1, ncmd:1, c0:10'h300, c1:10'h000, rv:2'b01, rd:8'h00, re:1'b1, wt:15};
      vecs[6] = '{who:1, we:0, addr:8'h12, wdata:8'h00, dly:3,  ncmd:2, c0:10'h212, c1:10'h300, rv:2'b10, rd:8'h3C, re:1'b0, wt:3};
      vecs[7] = '{who:1, we:1, addr:8'h13, wdata:8'h55, dly:-1, ncmd:2, c0:10'h013, c1:10'h155, rv:2'b00, rd:8'h00, re:1'b0, wt:0};
      vecs[8] = '{who:0, we:0, addr:8'h13, wdata:8'h00, dly:1,  ncmd:2, c0:10'h213, c1:10'h300, rv:2'b01, rd:8'h55, re:1'b0, wt:1};

      rst_n = 1'b0;
      req_valid = 2'b00; req_we = 2'b00; req_addr = 16'h0; req_wdata = 16'h0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_outputs", {8'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

      // Reset asserted while the read sits in R_WAIT.
      ram_dly = -1;
      @(negedge clk);
      req_valid = 2'b01; req_we[0] = 1'b0; req_addr[7:0] = 8'h40;
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 10) begin
         @(negedge clk); #1; n++;
      end
      chk("rw_grant", 32'(req_ready), 32'(2'b01));
      @(negedge clk);
      req_valid = 2'b00;
      #1;
      n = 0;
      while (!(ram_rx_valid && ram_din == 10'h300) && n < 10) begin
         @(negedge clk); #1; n++;
      end
      chk("rw_rcmd_seen", 32'(n < 10), 32'd1);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rw_outputs_in_reset", {8'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, ram_din, ram_rx_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin
         @(negedge clk); #1;
         if (rsp_valid != 2'b00) seen = 1;
      end
      chk("rw_no_rsp_after_reset", 32'(seen), 32'd0);

      // Both requesters busy right after reset: grants alternate, one every 3 cycles.
      @(negedge clk);
      req_we = 2'b11;
      req_addr = {8'h30, 8'h20};
      req_wdata = {8'h02, 8'h01};
      req_valid = 2'b11;
      gcnt = 0; have_cmd = 0; first_cmd = '0;
      for (int c = 0; c < 40 && gcnt < 4; c++) begin
         #1;
         if (ram_rx_valid && !have_cmd) begin
            have_cmd = 1; first_cmd = ram_din;
         end
         if (req_ready != 2'b00) begin
            gvec[gcnt] = req_ready; gcyc[gcnt] = c; gcnt++;
         end
         @(negedge clk);
      end
      req_valid = 2'b00;
      #1;
      if (ram_rx_valid && !have_cmd) begin
         have_cmd = 1; first_cmd = ram_din;
      end
      chk("rr_grant_count", 32'(gcnt), 32'd4);
      chk("rr_grant0", 32'(gvec[0]), 32'(2'b01));
      chk("rr_grant1", 32'(gvec[1]), 32'(2'b10));
      chk("rr_grant2", 32'(gvec[2]), 32'(2'b01));
      chk("rr_grant3", 32'(gvec[3]), 32'(2'b10));
      chk("rr_spacing1", 32'(gcyc[1] - gcyc[0]), 32'd3);
      chk("rr_spacing3", 32'(gcyc[3] - gcyc[2]), 32'd3);
      chk("rr_first_cmd_waddr", 32'(first_cmd), 32'(10'h020));
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
